uart_rx: RTL



---
 rtl/uart_rx_if.sv | 10 +
 rtl/uart_rx.sv | 132 +++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Byte handshake between the UART receiver and the RX byte FIFO.
// The receiver drives data/valid and the FIFO drives ready.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// Oversampled 8N1 UART receiver. It holds one completed byte for the downstream FIFO
// and reports framing and overrun errors as one-cycle pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    uart_rx_if.master  rx_if,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    sync_q;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          oerr_q, oerr_d;
    logic          rxd_s;
    logic          bit_tick, half_tick, byte_done, frame_bad;

    assign rxd_s = sync_q[1];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxd_s) state_d = START;
            end
            START: begin
                if (half_tick) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A line that is high again at mid start bit was only a glitch.
                    state_d = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rxd_s;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    state_d = rxd_s ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (rxd_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        busy      = (state_q != IDLE);
        half_tick = (cnt_q == HALF_LAST);
        bit_tick  = (cnt_q == BIT_LAST);
        byte_done = (state_q == STOP) && bit_tick && rxd_s;
        frame_bad = (state_q == STOP) && bit_tick && !rxd_s;
    end

    // Holding register and handshake. A same-cycle accept frees the slot for the new byte.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (valid_q && rx_if.rx_ready) valid_d = 1'b0;
        if (byte_done && (!valid_q || rx_if.rx_ready)) begin
            data_d  = shift_q;
            valid_d = 1'b1;
        end
        ferr_d = frame_bad;
        oerr_d = byte_done && valid_q && !rx_if.rx_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rxd};
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
        end
    end

    assign rx_if.rx_data  = data_q;
    assign rx_if.rx_valid = valid_q;
    assign frame_err      = ferr_q;
    assign overrun_err    = oerr_q;
endmodule
